// File: rtl/maquina_de_cafe_fsm.sv
// Coffee/tea vending controller: coin -> water check -> selection -> payment -> timed dispense.
// Moore action code on out; change is returned when coffee is paid with a 10 coin.
module maquina_de_cafe_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       hm,
  input  logic       ha,
  input  logic       bp,
  input  logic       bc,
  input  logic       bt,
  input  logic       hc,
  input  logic       md,
  input  logic       mc,
  output logic [2:0] out
);

  typedef enum logic [3:0] {
    IDLE        = 4'b0000,
    CHK_AGUA    = 4'b0001,
    SELECCION   = 4'b0010,
    CHK_CAFE    = 4'b0011,
    PAGO_TE     = 4'b0100,
    PAGO_CAFE   = 4'b0101,
    SERVIR_TE   = 4'b0110,
    SERVIR_CAFE = 4'b0111,
    DEVOLVER    = 4'b1000
  } state_t;

  state_t     state, nxt;
  logic [2:0] cnt;
  logic       chg;
  logic       serving;

  assign serving = (state == SERVIR_TE) || (state == SERVIR_CAFE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      chg   <= 1'b0;
    end else begin
      state <= nxt;
      // counter sits at 0 outside dispense, so entry always starts from 0
      cnt   <= serving ? cnt + 3'd1 : 3'd0;
      if (nxt == IDLE)
        chg <= 1'b0;
      else if (state == PAGO_CAFE && md)
        chg <= 1'b1;
      else if (state == PAGO_CAFE && mc)
        chg <= 1'b0;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (hm) nxt = CHK_AGUA;
      CHK_AGUA:  nxt = ha ? SELECCION : DEVOLVER;
      SELECCION: begin
        if (bp && bc)      nxt = CHK_CAFE;
        else if (bp && bt) nxt = PAGO_TE;
      end
      CHK_CAFE:  nxt = hc ? PAGO_CAFE : DEVOLVER;
      PAGO_CAFE: if (md || mc) nxt = SERVIR_CAFE;
      PAGO_TE: begin
        if (md)      nxt = SERVIR_TE;
        else if (mc) nxt = DEVOLVER;
      end
      SERVIR_TE, SERVIR_CAFE: if (cnt == 3'd7) nxt = IDLE;
      DEVOLVER:  nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    out = 3'b000;
    case (state)
      CHK_AGUA, SELECCION, CHK_CAFE, PAGO_CAFE, PAGO_TE: out = 3'b001;
      SERVIR_CAFE: out = chg ? 3'b111 : 3'b010;
      SERVIR_TE:   out = 3'b011;
      DEVOLVER:    out = 3'b111;
      default:     out = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_maquina_de_cafe_fsm.sv
// Scoreboard bench: each directed vector queues the out value expected after the next edge;
// a monitor pops and compares once that edge has passed.
module tb_maquina_de_cafe_fsm;

  logic       clk = 1'b0;
  logic       rst, hm, ha, bp, bc, bt, hc, md, mc;
  logic [2:0] out;

  typedef struct {
    logic [2:0] exp;
    int         due;
    int         id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vid = 0;

  maquina_de_cafe_fsm dut (
    .clk(clk), .rst(rst), .hm(hm), .ha(ha), .bp(bp), .bc(bc), .bt(bt),
    .hc(hc), .md(md), .mc(mc), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // input bits: {rst,hm,ha,bp,bc,bt,hc,md,mc}
  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] RST  = 9'b1_0000_0000;
  localparam logic [8:0] HM   = 9'b0_1000_0000;
  localparam logic [8:0] HA   = 9'b0_0100_0000;
  localparam logic [8:0] BP   = 9'b0_0010_0000;
  localparam logic [8:0] BC   = 9'b0_0001_0000;
  localparam logic [8:0] BT   = 9'b0_0000_1000;
  localparam logic [8:0] HC   = 9'b0_0000_0100;
  localparam logic [8:0] MD   = 9'b0_0000_0010;
  localparam logic [8:0] MC   = 9'b0_0000_0001;
  localparam logic [8:0] JUNK = 9'b0_1111_1111;

  task automatic vec(input logic [8:0] in, input logic [2:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, hm, ha, bp, bc, bt, hc, md, mc} = in;
    e.exp = exp;
    e.due = cyc + 1;
    e.id  = vid;
    vid++;
    q.push_back(e);
  endtask

  task automatic vec_n(input int n, input logic [8:0] in, input logic [2:0] exp);
    for (int i = 0; i < n; i++) vec(in, exp);
  endtask

  // monitor: sample 3 time units after each edge
  initial begin
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (out !== e.exp) begin
          errors++;
          $display("FAIL vec%0d out: got %b expected %b", e.id, out, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    {rst, hm, ha, bp, bc, bt, hc, md, mc} = 9'b1_0000_0000;
    vec(RST, 3'b000);
    vec(NONE, 3'b000);
    // coffee paid with 10: change returned, junk inputs ignored while dispensing
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BC, 3'b001);
    vec(HC, 3'b001);
    vec(MD, 3'b111);
    vec_n(7, JUNK, 3'b111);
    vec(NONE, 3'b000);
    vec(NONE, 3'b000);
    // coffee paid with 5: change flag must have cleared
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BC, 3'b001);
    vec(HC, 3'b001);
    vec(NONE, 3'b001);
    vec(MC, 3'b010);
    vec_n(7, NONE, 3'b010);
    vec(NONE, 3'b000);
    // tea paid with 10
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BT, 3'b001);
    vec(NONE, 3'b001);
    vec(MD, 3'b011);
    vec_n(7, JUNK, 3'b011);
    vec(NONE, 3'b000);
    // tea paid with 5: refund
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BT, 3'b001);
    vec(MC, 3'b111);
    vec(MC, 3'b000);
    // no water
    vec(HM, 3'b001);
    vec(NONE, 3'b111);
    vec(NONE, 3'b000);
    // no coffee
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BC, 3'b001);
    vec(NONE, 3'b111);
    vec(NONE, 3'b000);
    // waiting in SELECCION, then bc beats bt, md beats mc
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec_n(5, BC | BT, 3'b001);
    vec(BP, 3'b001);
    vec(BP | BC | BT, 3'b001);
    vec(HC, 3'b001);
    vec(MD | MC, 3'b111);
    vec_n(7, NONE, 3'b111);
    vec(NONE, 3'b000);
    // bt-only path would reach PAGO_TE where md serves tea; bc priority shown above
    // reset on 3rd cycle of SERVIR_CAFE
    vec(HM, 3'b001);
    vec(HA, 3'b001);
    vec(BP | BC, 3'b001);
    vec(HC, 3'b001);
    vec(MC, 3'b010);
    vec(NONE, 3'b010);
    vec(RST | HM, 3'b000);
    vec(NONE, 3'b000);
    vec(HM, 3'b001);
    vec(RST, 3'b000);
    vec(NONE, 3'b000);
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
